trojan_seq_trigger: RTL and testbench
=====================================

Name: trojan_seq_trigger

Overview:
- Parametrised counter-plus-sequence-triggered payload benchmark for the detection dataset.
- Generalises the fixed 16-bit, counter-only, add-constant benchmark in four ways:
  - configurable data and counter widths;
  - two-stage trigger: a beat-count threshold followed by a consecutive data-pattern match;
  - selectable payload mode;
  - bounded payload duration.
- Sits inline on a valid-qualified datapath with 1-cycle registered latency. Serves as golden RTL for trojan-inserted netlist generation.

Parameters:
- DATA_W, 16, datapath width.
- CNT_W, 8, beat-counter width.
- TRIG_COUNT, 255, counter value that arms the trigger (must be < 2^CNT_W).
- PATTERN, 16'hA5A5, DATA_W-bit match word checked while armed.
- SEQ_LEN, 2, consecutive matching beats required to fire (1..15).
- ARM_TIMEOUT, 16, armed beats allowed before disarm (must be >= SEQ_LEN).
- PAYLOAD_MODE, 0, payload type: 0 = ADD, 1 = XOR, 2 = ZERO.
- PAYLOAD_CONST, 2, DATA_W-bit operand for ADD/XOR.
- PAYLOAD_CYCLES, 3, valid beats corrupted per firing (>= 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input beat qualifier
- data_in  in  DATA_W  input data
- out_valid  out  1  output beat qualifier
- data_out  out  DATA_W  output data, possibly corrupted
- trig_active  out  1  high while in FIRE (observation only)

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high. All state updates on posedge clk.
- Reset values: out_valid=0, data_out=0, trig_active=0, state=IDLE, cnt=0, match_cnt=0, arm_cnt=0, fire_cnt=0.
- Datapath:
  - out_valid <= in_valid, every cycle.
  - When in_valid=1: data_out <= f(data_in), where f is the payload if state==FIRE at that edge, else identity.
  - When in_valid=0: data_out holds its value.
  - Latency is exactly 1 cycle. No backpressure.
- Payload arithmetic:
  - ADD: data_in + PAYLOAD_CONST, truncated to DATA_W (wraps mod 2^DATA_W).
  - XOR: data_in ^ PAYLOAD_CONST.
  - ZERO: all-zeros.
- All counters advance only on in_valid=1 beats. Idle cycles freeze every counter and the state.
- IDLE:
  - Each valid beat: cnt <= cnt+1, wrapping at 2^CNT_W.
  - If in_valid and cnt==TRIG_COUNT: go to ARMED, clear match_cnt and arm_cnt. cnt still increments on that beat.
- ARMED:
  - Each valid beat: arm_cnt++.
  - data_in==PATTERN: match_cnt++. Otherwise match_cnt <= 0.
  - When the beat brings match_cnt to SEQ_LEN: go to FIRE and clear fire_cnt. The completing beat itself is not corrupted.
  - Else, if arm_cnt reaches ARM_TIMEOUT on this beat: go to IDLE and clear cnt.
  - A match completion and a timeout on the same beat resolve to FIRE.
- FIRE:
  - Each valid beat is corrupted and fire_cnt++.
  - On the beat with fire_cnt==PAYLOAD_CYCLES-1: go to IDLE and clear cnt.
  - PATTERN beats are ignored while in FIRE.
- trig_active is registered and equals (state==FIRE).
- Re-arm needs a full new TRIG_COUNT+1 beats from cnt=0.
- rst asserted in any state, including mid-FIRE, restores reset values on the next edge. The in-flight beat is dropped (out_valid=0).

Decomposition:
- Package trojan_pkg holds:
  - state enum {IDLE, ARMED, FIRE};
  - payload mode localparams PM_ADD=0, PM_XOR=1, PM_ZERO=2;
  - a payload function f(mode, const, data).
- Sub-module trojan_trigger_fsm owns cnt, match_cnt, arm_cnt, fire_cnt and state. Its outputs are fire (state==FIRE) and state.
- Top level contains only the output register and payload mux.

Test Plan:
- Reset/latency: drive 300 beats of 16'h1234 with no PATTERN. Expect data_out=16'h1234 one cycle after each beat, trig_active=0, and no corruption even when cnt wraps from 255 to 0.
- Full trigger, ADD mode:
  - Stimulus: 256 beats of 16'h0000, then 16'hA5A5, 16'hA5A5, then 16'h0010, 16'hFFFF, 16'h0020, 16'h0030.
  - Expect outputs 16'h0012, 16'h0001 (wrap), 16'h0022, then 16'h0030 uncorrupted.
  - Expect trig_active high for exactly those 3 valid beats.
- Broken sequence and timeout:
  - After arming, send A5A5, 0000, A5A5, A5A5. Expect FIRE only after the final A5A5.
  - Separately, send 16 non-matching beats after arming. Expect return to IDLE, then 256 further beats needed to re-arm.
- Gapped valid: insert in_valid=0 cycles between every beat of the ADD scenario. Expect an identical corrupted-beat sequence, with data_out held during gaps.
- Modes: with PAYLOAD_MODE=1, CONST=16'h00FF, in FIRE, input 16'h1234 gives 16'h12CB. With PAYLOAD_MODE=2, any input gives 16'h0000.
- Reset mid-FIRE: assert rst on the 2nd FIRE beat. Next cycle expect all outputs 0 and state IDLE, then normal passthrough after release.

Source files
------------

// File: rtl/trojan_pkg.sv
// Shared types and payload arithmetic for the sequence-triggered trojan benchmark.
// The payload helper works on a fixed maximum width; callers zero-extend and truncate.
package trojan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam int PM_ADD  = 0;
    localparam int PM_XOR  = 1;
    localparam int PM_ZERO = 2;

    localparam int MAX_W = 64;

    // Truncating the 64-bit sum back to the datapath width gives the mod-2^DATA_W wrap.
    function automatic logic [MAX_W-1:0] payload_f(
        input int               mode,
        input logic [MAX_W-1:0] k,
        input logic [MAX_W-1:0] d
    );
        logic [MAX_W-1:0] r;
        case (mode)
            PM_ADD:  r = d + k;
            PM_XOR:  r = d ^ k;
            PM_ZERO: r = '0;
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trojan_trigger_fsm.sv
// Two-stage trigger: beat counter arms, then SEQ_LEN consecutive PATTERN beats fire
// for PAYLOAD_CYCLES valid beats. Every counter and the state freeze on idle cycles.
module trojan_trigger_fsm
    import trojan_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                CNT_W          = 8,
    parameter int                TRIG_COUNT     = 255,
    parameter logic [DATA_W-1:0] PATTERN        = 16'hA5A5,
    parameter int                SEQ_LEN        = 2,
    parameter int                ARM_TIMEOUT    = 16,
    parameter int                PAYLOAD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              fire,
    output state_t            state
);

    localparam int AW = $clog2(ARM_TIMEOUT + 1);
    localparam int MW = 4;
    localparam int FW = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt;
    logic [MW-1:0]    match_cnt;
    logic [AW-1:0]    arm_cnt;
    logic [FW-1:0]    fire_cnt;

    logic [MW-1:0]    match_nxt;
    logic [AW-1:0]    arm_nxt;
    logic             seq_done;
    logic             timed_out;
    logic             fire_last;

    always_comb begin
        arm_nxt   = arm_cnt + 1'b1;
        match_nxt = (data_in == PATTERN) ? match_cnt + 1'b1 : '0;
        seq_done  = (match_nxt == MW'(SEQ_LEN));
        timed_out = (arm_nxt == AW'(ARM_TIMEOUT));
        fire_last = (fire_cnt == FW'(PAYLOAD_CYCLES - 1));
    end

    // Match completion takes priority over timeout on the same beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fire      <= 1'b0;
            cnt       <= '0;
            match_cnt <= '0;
            arm_cnt   <= '0;
            fire_cnt  <= '0;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(TRIG_COUNT)) begin
                        state     <= ARMED;
                        match_cnt <= '0;
                        arm_cnt   <= '0;
                    end
                end
                ARMED: begin
                    arm_cnt   <= arm_nxt;
                    match_cnt <= match_nxt;
                    if (seq_done) begin
                        state    <= FIRE;
                        fire     <= 1'b1;
                        fire_cnt <= '0;
                    end else if (timed_out) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                FIRE: begin
                    fire_cnt <= fire_cnt + 1'b1;
                    if (fire_last) begin
                        state <= IDLE;
                        fire  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    fire  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/trojan_seq_trigger.sv
// Inline valid-qualified datapath with 1-cycle latency; beats accepted while the
// trigger is in FIRE are replaced by the configured payload.
module trojan_seq_trigger
    import trojan_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                CNT_W          = 8,
    parameter int                TRIG_COUNT     = 255,
    parameter logic [DATA_W-1:0] PATTERN        = 16'hA5A5,
    parameter int                SEQ_LEN        = 2,
    parameter int                ARM_TIMEOUT    = 16,
    parameter int                PAYLOAD_MODE   = 0,
    parameter logic [DATA_W-1:0] PAYLOAD_CONST  = 16'h0002,
    parameter int                PAYLOAD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              trig_active
);

    state_t            state;
    logic              fire;
    logic [DATA_W-1:0] corrupted;

    trojan_trigger_fsm #(
        .DATA_W         (DATA_W),
        .CNT_W          (CNT_W),
        .TRIG_COUNT     (TRIG_COUNT),
        .PATTERN        (PATTERN),
        .SEQ_LEN        (SEQ_LEN),
        .ARM_TIMEOUT    (ARM_TIMEOUT),
        .PAYLOAD_CYCLES (PAYLOAD_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .data_in  (data_in),
        .fire     (fire),
        .state    (state)
    );

    assign corrupted   = DATA_W'(payload_f(PAYLOAD_MODE, MAX_W'(PAYLOAD_CONST), MAX_W'(data_in)));
    assign trig_active = fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                data_out <= (state == FIRE) ? corrupted : data_in;
        end
    end

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// Scoreboard bench: three instances (ADD / XOR / ZERO payloads) share one stimulus
// stream; a reference model pushes expected outputs, a monitor pops and compares.
module tb_trojan_seq_trigger;

    localparam logic [15:0] PAT = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;

    logic        ov0, ov1, ov2;
    logic [15:0] do0, do1, do2;
    logic        ta0, ta1, ta2;

    always #5 clk = ~clk;

    trojan_seq_trigger #(.PAYLOAD_MODE(0), .PAYLOAD_CONST(16'h0002)) u_add (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov0), .data_out(do0), .trig_active(ta0));
    trojan_seq_trigger #(.PAYLOAD_MODE(1), .PAYLOAD_CONST(16'h00FF)) u_xor (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov1), .data_out(do1), .trig_active(ta1));
    trojan_seq_trigger #(.PAYLOAD_MODE(2), .PAYLOAD_CONST(16'h0002)) u_zero (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov2), .data_out(do2), .trig_active(ta2));

    int pass_cnt = 0;
    int total    = 0;

    logic [47:0] expq[$];
    logic [47:0] exp_hold  = '0;
    logic        exp_valid = 1'b0;
    logic        exp_trig  = 1'b0;
    bit          mon_en    = 1'b0;

    // Model: phase 0 counting, 1 waiting for the pattern run, 2 corrupting.
    int phase = 0, cnt = 0, run = 0, armed = 0, fired = 0;

    function automatic logic [47:0] outputs_for(input logic [15:0] d, input bit corrupt);
        logic [15:0] a, x;
        if (!corrupt) return {d, d, d};
        a = 16'((32'(d) + 32'h0002) % 32'h10000);
        x = d ^ 16'h00FF;
        return {16'h0000, x, a};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit r, input bit v, input logic [15:0] d);
        logic [47:0] e;
        @(negedge clk);
        rst = r; in_valid = v; data_in = d;
        if (r) begin
            phase = 0; cnt = 0; run = 0; armed = 0; fired = 0;
            exp_hold = '0; exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                e = outputs_for(d, phase == 2);
                expq.push_back(e);
                exp_hold = e;
                case (phase)
                    0: begin
                        if (cnt == 255) begin phase = 1; run = 0; armed = 0; end
                        cnt = (cnt + 1) % 256;
                    end
                    1: begin
                        armed++;
                        run = (d == PAT) ? run + 1 : 0;
                        if (run == 2) begin phase = 2; fired = 0; end
                        else if (armed == 16) begin phase = 0; cnt = 0; end
                    end
                    default: begin
                        fired++;
                        if (fired == 3) begin phase = 0; cnt = 0; end
                    end
                endcase
            end
        end
        exp_trig = (phase == 2);
    endtask

    task automatic beats(input int n, input logic [15:0] d, input bit gap);
        for (int i = 0; i < n; i++) begin
            step(0, 1, d);
            if (gap) step(0, 0, 16'($urandom));
        end
    endtask

    task automatic do_reset();
        step(1, 0, 16'h0);
        step(1, 1, 16'hDEAD);
    endtask

    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            chk("out_valid", {45'd0, ov2, ov1, ov0}, {45'd0, {3{exp_valid}}});
            chk("trig_active", {45'd0, ta2, ta1, ta0}, {45'd0, {3{exp_trig}}});
            if (ov0) begin
                if (expq.size() == 0) chk("unexpected_beat", 48'd1, 48'd0);
                else chk("data_out", {do2, do1, do0}, expq.pop_front());
            end else begin
                chk("data_hold", {do2, do1, do0}, exp_hold);
            end
        end
    end

    initial begin
        step(1, 0, 16'h0);
        mon_en = 1'b1;
        step(1, 0, 16'h0);

        // passthrough across a counter wrap
        beats(300, 16'h1234, 0);

        // full trigger, then the same with idle gaps
        for (int g = 0; g < 2; g++) begin
            do_reset();
            beats(256, 16'h0000, g != 0);
            beats(2, PAT, g != 0);
            beats(1, 16'h0010, g != 0);
            beats(1, 16'hFFFF, g != 0);
            beats(1, 16'h0020, g != 0);
            beats(1, 16'h0030, g != 0);
            beats(3, 16'h0040, g != 0);
        end

        // broken sequence then fire on 1234
        do_reset();
        beats(256, 16'h0000, 0);
        beats(1, PAT, 0);
        beats(1, 16'h0000, 0);
        beats(2, PAT, 0);
        beats(4, 16'h1234, 0);

        // timeout, then full re-arm
        do_reset();
        beats(256, 16'h0000, 0);
        beats(16, 16'h0001, 0);
        beats(2, PAT, 0);
        beats(254, 16'h0000, 0);
        beats(2, PAT, 0);
        beats(4, 16'h5678, 0);

        // reset on the second FIRE beat
        do_reset();
        beats(256, 16'h0000, 0);
        beats(2, PAT, 0);
        beats(1, 16'h1234, 0);
        step(1, 1, 16'h1234);
        beats(5, 16'h4321, 0);

        // randomized traffic with pattern-heavy data and rare resets
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) == 0)
                step(1, 1'($urandom), 16'($urandom));
            else
                step(0, $urandom_range(0, 4) != 0,
                     ($urandom_range(0, 2) == 0) ? PAT : 16'($urandom));
        end

        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        @(negedge clk);
        mon_en = 1'b0;
        chk("queue_drained", 48'(expq.size()), 48'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
